soma_ctrl: RTL and testbench
============================

# soma_ctrl

Controller in front of one `soma` instance.
- Loads the four neuron parameters through a config port, then pulses the soma's active-low reset so it latches them.
- Round-robin arbitrates spike events from `NUM_REQ` requesters onto the soma's single input, one event per cycle at most.
- Blocks issue while the neuron is refractory and handles the kill/dead condition.
- Sits between the synapse/router fabric and the soma datapath.

## Interface
- `NUM_REQ`, default 4: number of spike requesters (2..16).
- `W_DATA`, default 8: width of time, weight and parameter fields.
- `INIT_CYC`, default 2: cycles `soma_rst_n` is held low after config.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `cfg_valid` in 1: config write request.
- `cfg_ready` out 1: config write accepted (high only in CONFIG).
- `cfg_addr` in 2: parameter select; 0 = V_th, 1 = V_leak, 2 = refr_time, 3 = axon_delay.
- `cfg_data` in W_DATA: parameter value.
- `cfg_done` in 1: end of configuration, single-cycle pulse.
- `req_valid` in NUM_REQ: per-requester event valid.
- `req_time` in NUM_REQ*W_DATA: per-requester spike time (inter-spike delta).
- `req_weight` in NUM_REQ*W_DATA: per-requester synaptic weight.
- `req_ready` out NUM_REQ: one-hot grant; an event transfers when valid & ready.
- `kill` in 1: permanently deactivate the neuron until `rst`.
- `soma_fire` in 1: single-cycle pulse from the soma on output spike.
- `soma_rst_n` out 1: active-low reset to the soma.
- `soma_V_th`, `soma_V_leak`, `soma_refr_time`, `soma_axon_delay` out W_DATA each: parameter registers.
- `soma_spike` out W_DATA: issued spike time.
- `soma_weight` out W_DATA: issued weight.
- `soma_valid` out 1: issued event valid.
- `soma_kill` out 1: kill to the soma.
- `state` out 3: current FSM state.
- `grant_id` out $clog2(NUM_REQ): index of the last granted requester.

## Operation
- **States:** CONFIG, INIT, RUN, REFR, DEAD.
- **Reset** (`rst` high at an edge, from any state, including mid-INIT and mid-REFR):
  - state = CONFIG; all parameter registers 0; RR pointer 0; counters 0.
  - `soma_rst_n` = 0, `soma_valid` = 0, `soma_kill` = 0, `req_ready` = 0, `cfg_ready` = 1, `grant_id` = 0.
- **CONFIG:**
  - Each cycle with `cfg_valid` high writes `cfg_data` to the register at `cfg_addr`; the last write to an address wins.
  - `cfg_done` moves to INIT. If `cfg_valid` and `cfg_done` are high in the same cycle, the write lands first.
- **INIT:**
  - `soma_rst_n` held 0 for `INIT_CYC` cycles, then the state moves to RUN.
  - `soma_rst_n` = 1 in RUN, REFR and DEAD.
- **RUN:**
  - Grant goes to the lowest index ≥ RR pointer with `req_valid` set, wrapping around.
  - On a grant: the pointer becomes grant+1 mod `NUM_REQ`; `soma_spike`/`soma_weight` register the granted fields; `soma_valid` = 1 the next cycle, otherwise 0.
  - With no valid requesters: no grant, and the pointer is unchanged.
- **REFR:** entered the cycle after a `soma_fire` pulse in RUN.
  - On entry the refractory counter loads `soma_refr_time`; it decrements each cycle and the state returns to RUN when it reaches 0.
  - `refr_time` = 0 gives exactly one REFR cycle.
  - `req_ready` = 0 throughout REFR.
  - A `soma_fire` received during REFR is ignored.
- **Kill:** `kill` in RUN or REFR moves to DEAD next cycle.
  - DEAD is absorbing until `rst`; `req_ready` = 0 and `soma_kill` = 1 there.
  - `kill` in CONFIG or INIT is latched and applied on entry to RUN.
- **Simultaneous events:**
  - `soma_fire` and a grant in the same RUN cycle: the grant completes and REFR follows.
  - `kill` and `soma_fire` together: `kill` wins.

## Timing
- Request → soma: 1 cycle (grant at edge t; `soma_valid` high during t+1).
- Throughput: 1 event per cycle in RUN.
- `req_ready` is combinational from `req_valid`, the RR pointer and the state. Requesters must not make `req_valid` depend on `req_ready`.
- Config → first grant: `cfg_done` at t; INIT covers t+1..t+`INIT_CYC`; RUN from t+`INIT_CYC`+1.
- `soma_fire` at t → REFR from t+1 through t+1+`refr_time`; RUN again at t+2+`refr_time`.

## Configuration
- `SOMA_CTRL_STATS_EN`: when defined, adds two 32-bit output counters.
  - `stat_events` counts issued events.
  - `stat_fires` counts accepted `soma_fire` pulses.
  - Both clear on `rst` and saturate at all-ones.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

## Structure
- Shared package `snn_pkg`:
  - FSM state enum (CONFIG=0, INIT=1, RUN=2, REFR=3, DEAD=4).
  - Config address constants.
  - `W_DATA` default.
- Sub-module `rr_arbiter`: parameterised by N; inputs `req` and `advance`; outputs one-hot `grant` and `grant_idx`.

## Test plan
- **Config and init:** write V_th=20, V_leak=1, refr_time=3, axon_delay=2; pulse `cfg_done` → parameter outputs show these values; `soma_rst_n` low exactly 2 cycles; state RUN on the 3rd cycle.
- **Round robin:** all 4 `req_valid` held high in RUN → grants 0,1,2,3,0 on consecutive cycles; `soma_valid` high every cycle; `soma_weight` tracks the granted requester one cycle later.
- **Refractory:** `soma_fire` pulse with refr_time=3 → `req_ready`=0 for 4 cycles; next grant resumes at the saved RR pointer; refr_time=0 → exactly 1 blocked cycle.
- **Kill:** `kill` and `soma_fire` asserted together → DEAD, `soma_kill`=1, no further grants; `rst` → CONFIG with all outputs at reset values.
- **Reset mid-operation:** `rst` during REFR → CONFIG next cycle, parameters 0, `soma_rst_n`=0.
- **Stats:** with `SOMA_CTRL_STATS_EN`, 10 events and 2 fires → `stat_events`=10, `stat_fires`=2.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron fabric: soma controller FSM states,
// parameter-register addresses and the default datapath width.
package snn_pkg;

    typedef enum logic [2:0] {
        ST_CONFIG = 3'd0,
        ST_INIT   = 3'd1,
        ST_RUN    = 3'd2,
        ST_REFR   = 3'd3,
        ST_DEAD   = 3'd4
    } soma_state_e;

    localparam logic [1:0] CFG_V_TH       = 2'd0;
    localparam logic [1:0] CFG_V_LEAK     = 2'd1;
    localparam logic [1:0] CFG_REFR_TIME  = 2'd2;
    localparam logic [1:0] CFG_AXON_DELAY = 2'd3;

    localparam int W_DATA_DEF = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at an internal
// pointer; the pointer moves past the winner only on cycles where advance is set.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

    // An idle cycle (no requests) leaves the pointer where it was.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/soma_ctrl.sv
// Controller in front of one soma: parameter load, soma reset sequencing,
// round-robin spike issue, refractory blocking and kill. Optional SOMA_CTRL_STATS_EN adds event/fire counters.
module soma_ctrl
    import snn_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int W_DATA   = W_DATA_DEF,
    parameter int INIT_CYC = 2,
    parameter int IW       = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [1:0]                  cfg_addr,
    input  logic [W_DATA-1:0]           cfg_data,
    input  logic                        cfg_done,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*W_DATA-1:0]   req_time,
    input  logic [NUM_REQ*W_DATA-1:0]   req_weight,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        kill,
    input  logic                        soma_fire,
    output logic                        soma_rst_n,
    output logic [W_DATA-1:0]           soma_V_th,
    output logic [W_DATA-1:0]           soma_V_leak,
    output logic [W_DATA-1:0]           soma_refr_time,
    output logic [W_DATA-1:0]           soma_axon_delay,
    output logic [W_DATA-1:0]           soma_spike,
    output logic [W_DATA-1:0]           soma_weight,
    output logic                        soma_valid,
    output logic                        soma_kill,
    output logic [2:0]                  state,
    output logic [IW-1:0]               grant_id
`ifdef SOMA_CTRL_STATS_EN
    ,
    output logic [31:0]                 stat_events,
    output logic [31:0]                 stat_fires
`endif
);

    localparam logic [15:0] INIT_LOAD = 16'((INIT_CYC > 1) ? INIT_CYC - 1 : 0);

    soma_state_e         st;
    logic [15:0]         init_cnt;
    logic [W_DATA-1:0]   refr_cnt;
    logic                kill_lat;
    logic [NUM_REQ-1:0]  arb_grant;
    logic [IW-1:0]       arb_idx;
    logic                in_run;
    logic                issue;
    logic                fire_accept;

    // Handshake: a requester's event transfers on a rising edge where
    // req_valid[i] & req_ready[i]; req_ready is a combinational one-hot grant
    // that is only non-zero in RUN, so req_valid must never wait on req_ready.
    assign in_run      = (st == ST_RUN);
    assign issue       = in_run && (|req_valid);
    assign fire_accept = in_run && soma_fire && !kill;
    assign req_ready   = in_run ? arb_grant : '0;

    assign state      = st;
    assign cfg_ready  = (st == ST_CONFIG);
    assign soma_rst_n = (st == ST_RUN) || (st == ST_REFR) || (st == ST_DEAD);
    assign soma_kill  = (st == ST_DEAD);

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (in_run),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st              <= ST_CONFIG;
            init_cnt        <= '0;
            refr_cnt        <= '0;
            kill_lat        <= 1'b0;
            soma_V_th       <= '0;
            soma_V_leak     <= '0;
            soma_refr_time  <= '0;
            soma_axon_delay <= '0;
            soma_spike      <= '0;
            soma_weight     <= '0;
            soma_valid      <= 1'b0;
            grant_id        <= '0;
        end else begin
            soma_valid <= 1'b0;
            case (st)
                ST_CONFIG: begin
                    if (kill) kill_lat <= 1'b1;
                    if (cfg_valid) begin
                        case (cfg_addr)
                            CFG_V_TH:       soma_V_th       <= cfg_data;
                            CFG_V_LEAK:     soma_V_leak     <= cfg_data;
                            CFG_REFR_TIME:  soma_refr_time  <= cfg_data;
                            CFG_AXON_DELAY: soma_axon_delay <= cfg_data;
                            default:        ;
                        endcase
                    end
                    if (cfg_done) begin
                        st       <= ST_INIT;
                        init_cnt <= INIT_LOAD;
                    end
                end
                ST_INIT: begin
                    if (kill) kill_lat <= 1'b1;
                    // A kill seen before RUN takes effect at the RUN boundary.
                    if (init_cnt == '0) st <= (kill_lat || kill) ? ST_DEAD : ST_RUN;
                    else                init_cnt <= init_cnt - 16'd1;
                end
                ST_RUN: begin
                    if (issue) begin
                        soma_valid  <= 1'b1;
                        soma_spike  <= req_time[int'(arb_idx)*W_DATA +: W_DATA];
                        soma_weight <= req_weight[int'(arb_idx)*W_DATA +: W_DATA];
                        grant_id    <= arb_idx;
                    end
                    if (kill) begin
                        st <= ST_DEAD;
                    end else if (soma_fire) begin
                        st       <= ST_REFR;
                        refr_cnt <= soma_refr_time;
                    end
                end
                ST_REFR: begin
                    if (kill)                st <= ST_DEAD;
                    else if (refr_cnt == '0) st <= ST_RUN;
                    else                     refr_cnt <= refr_cnt - W_DATA'(1);
                end
                ST_DEAD: ;
                default: st <= ST_CONFIG;
            endcase
        end
    end

`ifdef SOMA_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_events <= '0;
            stat_fires  <= '0;
        end else begin
            if (issue && stat_events != '1)       stat_events <= stat_events + 32'd1;
            if (fire_accept && stat_fires != '1)  stat_fires  <= stat_fires + 32'd1;
        end
    end
`else
    logic unused_fire_accept;
    assign unused_fire_accept = fire_accept;
`endif

endmodule

// File: tb/tb_soma_ctrl.sv
// Self-checking bench for soma_ctrl: reference model of the FSM and round-robin
// pointer, expected issued events held in a queue and compared on soma_valid.
module tb_soma_ctrl;
    import snn_pkg::*;

    localparam int NR = 4;
    localparam int W  = 8;
    localparam int IC = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [1:0]      cfg_addr;
    logic [W-1:0]    cfg_data;
    logic            cfg_done;
    logic [NR-1:0]   req_valid;
    logic [NR*W-1:0] req_time;
    logic [NR*W-1:0] req_weight;
    logic [NR-1:0]   req_ready;
    logic            kill;
    logic            soma_fire;
    logic            soma_rst_n;
    logic [W-1:0]    soma_V_th, soma_V_leak, soma_refr_time, soma_axon_delay;
    logic [W-1:0]    soma_spike, soma_weight;
    logic            soma_valid;
    logic            soma_kill;
    logic [2:0]      state;
    logic [1:0]      grant_id;
`ifdef SOMA_CTRL_STATS_EN
    logic [31:0]     stat_events, stat_fires;
`endif

    soma_ctrl #(.NUM_REQ(NR), .W_DATA(W), .INIT_CYC(IC)) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .cfg_done        (cfg_done),
        .req_valid       (req_valid),
        .req_time        (req_time),
        .req_weight      (req_weight),
        .req_ready       (req_ready),
        .kill            (kill),
        .soma_fire       (soma_fire),
        .soma_rst_n      (soma_rst_n),
        .soma_V_th       (soma_V_th),
        .soma_V_leak     (soma_V_leak),
        .soma_refr_time  (soma_refr_time),
        .soma_axon_delay (soma_axon_delay),
        .soma_spike      (soma_spike),
        .soma_weight     (soma_weight),
        .soma_valid      (soma_valid),
        .soma_kill       (soma_kill),
        .state           (state),
        .grant_id        (grant_id)
`ifdef SOMA_CTRL_STATS_EN
        ,
        .stat_events     (stat_events),
        .stat_fires      (stat_fires)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard: {grant index, spike time, weight}
    logic [17:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // model of controller state
    int m_state, m_ptr, m_cnt, m_refr, m_ev, m_fi;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_stats();
`ifdef SOMA_CTRL_STATS_EN
        check_eq("stat_events", stat_events, 32'(m_ev));
        check_eq("stat_fires", stat_fires, 32'(m_fi));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_valid = 1'b0; cfg_done = 1'b0; cfg_addr = '0; cfg_data = '0;
        req_valid = '1; kill = 1'b0; soma_fire = 1'b0; req_time = '0; req_weight = '0;
        @(posedge clk); #1;
        check_eq("rst_state", 32'(state), 32'(ST_CONFIG));
        check_eq("rst_soma_rst_n", 32'(soma_rst_n), 32'd0);
        check_eq("rst_soma_valid", 32'(soma_valid), 32'd0);
        check_eq("rst_soma_kill", 32'(soma_kill), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check_eq("rst_grant_id", 32'(grant_id), 32'd0);
        check_eq("rst_params", {soma_V_th, soma_V_leak, soma_refr_time, soma_axon_delay}, 32'd0);
        m_state = 0; m_ptr = 0; m_cnt = 0; m_ev = 0; m_fi = 0;
        exp_q.delete();
        check_stats();
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [W-1:0] d, input logic done);
        cfg_valid = 1'b1; cfg_addr = a; cfg_data = d; cfg_done = done;
        check_eq("cfg_ready", 32'(cfg_ready), 32'd1);
        @(posedge clk); #1;
        cfg_valid = 1'b0; cfg_done = 1'b0;
    endtask

    // Called right after the cfg_done edge; INIT must last exactly IC cycles.
    task automatic init_seq(input int refr);
        req_valid = '1;
        for (int c = 0; c < IC; c++) begin
            check_eq("init_state", 32'(state), 32'(ST_INIT));
            check_eq("init_soma_rst_n", 32'(soma_rst_n), 32'd0);
            check_eq("init_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        check_eq("run_state", 32'(state), 32'(ST_RUN));
        check_eq("run_soma_rst_n", 32'(soma_rst_n), 32'd1);
        req_valid = '0;
        m_state = 2; m_refr = refr;
    endtask

    // driver: one cycle of requests/fire/kill, model predicts grant and next state
    task automatic step(input logic [NR-1:0] vm, input logic fire, input logic kl);
        logic [NR-1:0] eg;
        logic [17:0]   e;
        int            gi, idx;
        logic          pend;
        req_valid = vm; soma_fire = fire; kill = kl;
        for (int i = 0; i < NR; i++) begin
            req_time[i*W +: W]   = W'($urandom_range(0, 255));
            req_weight[i*W +: W] = W'($urandom_range(0, 255));
        end
        #1;
        eg = '0; gi = -1;
        if (m_state == 2) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (gi < 0 && vm[idx]) gi = idx;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        check_eq("req_ready", 32'(req_ready), 32'(eg));
        pend = (gi >= 0);
        if (pend) begin
            exp_q.push_back({2'(gi), req_time[gi*W +: W], req_weight[gi*W +: W]});
            m_ptr = (gi + 1) % NR;
            m_ev++;
        end
        case (m_state)
            2: if (kl) m_state = 4;
               else if (fire) begin m_state = 3; m_cnt = m_refr; m_fi++; end
            3: if (kl) m_state = 4;
               else if (m_cnt == 0) m_state = 2;
               else m_cnt--;
            default: ;
        endcase
        @(posedge clk); #1;
        soma_fire = 1'b0; kill = 1'b0;
        check_eq("state", 32'(state), 32'(m_state));
        check_eq("soma_valid", 32'(soma_valid), 32'(pend));
        check_eq("soma_kill", 32'(soma_kill), 32'(m_state == 4));
        if (pend) begin
            e = exp_q.pop_front();
            check_eq("soma_spike", 32'(soma_spike), 32'(e[15:8]));
            check_eq("soma_weight", 32'(soma_weight), 32'(e[7:0]));
            check_eq("grant_id", 32'(grant_id), 32'(e[17:16]));
        end
    endtask

    initial begin
        do_reset();

        // configuration with an overwritten address and write+done together
        cfg_write(CFG_V_TH, 8'd99, 1'b0);
        cfg_write(CFG_V_TH, 8'd20, 1'b0);
        cfg_write(CFG_V_LEAK, 8'd1, 1'b0);
        cfg_write(CFG_REFR_TIME, 8'd3, 1'b0);
        cfg_write(CFG_AXON_DELAY, 8'd2, 1'b1);
        check_eq("V_th", 32'(soma_V_th), 32'd20);
        check_eq("V_leak", 32'(soma_V_leak), 32'd1);
        check_eq("refr_time", 32'(soma_refr_time), 32'd3);
        check_eq("axon_delay", 32'(soma_axon_delay), 32'd2);
        check_eq("cfg_ready_init", 32'(cfg_ready), 32'd0);
        init_seq(3);

        // round robin, all requesters, then random masks
        repeat (8) step('1, 1'b0, 1'b0);
        repeat (10) step(NR'($urandom_range(0, 15)), 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);

        // fire with a grant, refractory of 4 cycles (fire inside REFR ignored)
        step('1, 1'b1, 1'b0);
        step('1, 1'b0, 1'b0);
        step('1, 1'b1, 1'b0);
        step('1, 1'b0, 1'b0);
        step('1, 1'b0, 1'b0);
        repeat (3) step('1, 1'b0, 1'b0);

        // kill and fire together
        step('1, 1'b1, 1'b1);
        repeat (3) step('1, 1'b0, 1'b0);
        step('1, 1'b0, 1'b1);
        check_stats();

        do_reset();

        // zero refractory time, then reset while refractory
        cfg_write(CFG_REFR_TIME, 8'd0, 1'b1);
        init_seq(0);
        repeat (2) step('1, 1'b0, 1'b0);
        step('1, 1'b1, 1'b0);
        step('1, 1'b0, 1'b0);
        step('1, 1'b0, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        check_eq("refr_before_rst", 32'(state), 32'(ST_REFR));
        check_stats();
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
